rv_ifu: RTL and testbench

Instruction fetch unit for the RV32I core; sits directly upstream of the decode/control stage.
- Generates sequential fetch addresses and issues requests on a req/gnt + rvalid instruction-memory interface.
- Buffers returned words in a small in-order FIFO and presents {pc, instr, opcode} to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered words and discarding in-flight responses.

---
 rtl/rv_ifu.sv | 132 +++++++++++++
 tb/tb_rv_ifu.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ifu.sv
// rv_ifu: RV32I instruction fetch unit with credit-limited req/gnt fetch, in-order buffer and redirect flush.
// Define RV_IFU_PERF_EN to add the perf_starve_o decode-starvation counter.
module rv_ifu #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o,
  output logic [6:0]      id_opcode_o
`ifdef RV_IFU_PERF_EN
  ,
  output logic [31:0]     perf_starve_o
`endif
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [0:0] {FETCH, DRAIN} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [CW-1:0]   count, count_next;
  logic [CW-1:0]   outstanding, outstanding_next;
  logic [CW-1:0]   discard, discard_next;
  logic [PW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic            grant, push, pop, req_next;

  logic [XLEN-1:0] tag_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [31:0]     instr_mem [FIFO_DEPTH];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through the block can infer a latch.
    grant            = imem_req_o & imem_gnt_i;
    pop              = id_valid_o & id_ready_i & ~redirect_i;
    push             = imem_rvalid_i & ~redirect_i & (discard == '0);
    outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);
    count_next       = redirect_i ? '0 : count + CW'(push) - CW'(pop);
    discard_next     = discard;
    state_next       = state;
    fetch_pc_next    = fetch_pc;

    if (redirect_i) begin
      // In DRAIN every outstanding word is already stale, so this also leaves discard unchanged there.
      discard_next  = outstanding_next;
      state_next    = (outstanding_next != '0) ? DRAIN : FETCH;
      fetch_pc_next = redirect_pc_i & ~XLEN'(3);
    end else begin
      if (imem_rvalid_i && discard != '0) discard_next = discard - CW'(1);
      if (grant) fetch_pc_next = fetch_pc + XLEN'(4);
      if (state == DRAIN && discard == '0) state_next = FETCH;
    end

    // Buffered plus in-flight words may never exceed the buffer, so a push always has room.
    req_next = (state_next == FETCH) &&
               (({1'b0, count_next} + {1'b0, outstanding_next}) < CREDITS);
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      imem_req_o  <= req_next;
      count       <= count_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      // Tags track every issued request, stale or not, so they stay aligned with responses.
      if (grant)         tag_wr <= tag_wr + PW'(1);
      if (imem_rvalid_i) tag_rd <= tag_rd + PW'(1);
    end
  end

  // NOTE: the storage arrays carry no reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      pc_mem[wr_ptr]    <= tag_mem[tag_rd];
      instr_mem[wr_ptr] <= imem_rdata_i;
    end
  end

  assign imem_addr_o = fetch_pc;
  assign id_valid_o  = (count != '0);
  assign id_pc_o     = id_valid_o ? pc_mem[rd_ptr] : '0;
  assign id_instr_o  = id_valid_o ? instr_mem[rd_ptr] : NOP;
  assign id_opcode_o = id_instr_o[6:0];

`ifdef RV_IFU_PERF_EN
  logic starve;
  assign starve = id_ready_i & ~id_valid_o & ~redirect_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                perf_starve_o <= '0;
    else if (starve && perf_starve_o != '1)   perf_starve_o <= perf_starve_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rv_ifu.sv
// tb_rv_ifu: self-checking bench for rv_ifu; a queue-based memory and decode model predicts every delivered entry.
// Inputs change and outputs are sampled on the falling edge; all DUT outputs are register-driven.
module tb_rv_ifu;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic [6:0]  id_opcode_o;
`ifdef RV_IFU_PERF_EN
  logic [31:0] perf_starve_o;
`endif

  rv_ifu #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .id_opcode_o   (id_opcode_o)
`ifdef RV_IFU_PERF_EN
    ,
    .perf_starve_o (perf_starve_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  pend_t       pend[$];   // granted requests awaiting a response, oldest first
  logic [31:0] mfifo[$];  // PCs the decode side should see, oldest first
  logic [31:0] mfetch;    // next address the fetch unit should request

  bit          prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;
  int          n_cmp, n_err, n_pops, n_grants;

  bit          o_req, o_grant, o_valid;
  logic [31:0] o_addr, o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A3C_0F13;
  endfunction

  task automatic model_reset();
    pend.delete();
    mfifo.delete();
    mfetch     = RPC;
    prev_req   = 0;
    prev_gnt   = 0;
    prev_redir = 0;
    prev_addr  = '0;
  endtask

  // One clock cycle: check the visible outputs, drive this cycle's inputs, advance the model past the edge.
  task automatic cycle(input bit g, input bit rv, input bit rdy, input bit redir, input logic [31:0] rpc);
    pend_t       r;
    bit          exp_valid, do_pop, any_stale;
    logic [31:0] w;
    @(negedge clk);
    exp_valid = (mfifo.size() != 0);
    o_req     = imem_req_o;
    o_addr    = imem_addr_o;
    o_valid   = id_valid_o;
    o_pc      = id_pc_o;

    n_cmp++;
    if (id_valid_o !== exp_valid) begin
      n_err++;
      $display("FAIL id_valid at %0t: got %b expected %b", $time, id_valid_o, exp_valid);
    end
    if (exp_valid) begin
      w = mem_word(mfifo[0]);
      n_cmp++;
      if (id_pc_o !== mfifo[0] || id_instr_o !== w || id_opcode_o !== w[6:0]) begin
        n_err++;
        $display("FAIL head_entry at %0t: got pc=%h instr=%h op=%b expected pc=%h instr=%h op=%b",
                 $time, id_pc_o, id_instr_o, id_opcode_o, mfifo[0], w, w[6:0]);
      end
    end else begin
      n_cmp++;
      if (id_pc_o !== 32'h0 || id_instr_o !== NOP || id_opcode_o !== 7'b0010011) begin
        n_err++;
        $display("FAIL empty_outputs at %0t: got pc=%h instr=%h op=%b expected pc=0 instr=%h op=0010011",
                 $time, id_pc_o, id_instr_o, id_opcode_o, NOP);
      end
    end
    if (prev_req && !prev_gnt && !prev_redir) begin
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
        n_err++;
        $display("FAIL req_hold at %0t: got req=%b addr=%h expected req=1 addr=%h",
                 $time, imem_req_o, imem_addr_o, prev_addr);
      end
    end
    if (imem_req_o === 1'b1) begin
      any_stale = 0;
      foreach (pend[i]) if (pend[i].stale) any_stale = 1;
      n_cmp++;
      if (mfifo.size() + pend.size() >= DEPTH || any_stale) begin
        n_err++;
        $display("FAIL req_credit at %0t: req=1 with buffered=%0d in_flight=%0d stale=%b (limit %0d)",
                 $time, mfifo.size(), pend.size(), any_stale, DEPTH);
      end
      if (g) begin
        n_cmp++;
        if (imem_addr_o !== mfetch) begin
          n_err++;
          $display("FAIL grant_addr at %0t: got %h expected %h", $time, imem_addr_o, mfetch);
        end
      end
    end

    imem_gnt_i    = g;
    id_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    if (rv && pend.size() != 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end

    do_pop = exp_valid && rdy && !redir;
    if (do_pop) begin
      void'(mfifo.pop_front());
      n_pops++;
    end
    if (imem_rvalid_i) begin
      r = pend.pop_front();
      if (!redir && !r.stale) mfifo.push_back(r.addr);
    end
    o_grant = (imem_req_o === 1'b1) && g;
    if (o_grant) begin
      pend.push_back('{addr: mfetch, stale: 1'b0});
      mfetch = mfetch + 32'd4;
      n_grants++;
    end
    if (redir) begin
      mfifo.delete();
      foreach (pend[i]) pend[i].stale = 1;
      mfetch = rpc & ~32'h3;
    end
    prev_req   = (imem_req_o === 1'b1);
    prev_gnt   = g;
    prev_redir = redir;
    prev_addr  = imem_addr_o;
  endtask

  task automatic drain();
    int k = 0;
    while ((mfifo.size() != 0 || pend.size() != 0) && k < 40) begin
      cycle(0, 1, 1, 0, '0);
      k++;
    end
    n_cmp++;
    if (mfifo.size() != 0 || pend.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got buffered=%0d in_flight=%0d after 40 cycles, expected 0/0",
               mfifo.size(), pend.size());
    end
    cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 1, 0, '0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RPC || id_valid_o !== 1'b0 ||
        id_pc_o !== 32'h0 || id_instr_o !== NOP || id_opcode_o !== 7'b0010011) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b addr=%h valid=%b pc=%h instr=%h op=%b expected 0/%h/0/0/%h/0010011",
               imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_instr_o, id_opcode_o, RPC, NOP);
    end
    rstn = 1'b1;
    cycle(0, 0, 1, 0, '0);
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== RPC) begin
      n_err++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", o_req, o_addr, RPC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] gaddr[30];
    bit          gok[30];
    int          ng = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 1, 0, '0);
      gok[i]   = o_grant;
      gaddr[i] = o_addr;
      if (o_grant && ng < 3) begin
        n_cmp++;
        if (o_addr !== RPC + 32'(4 * ng)) begin
          n_err++;
          $display("FAIL stream_addr: got %h expected %h", o_addr, RPC + 32'(4 * ng));
        end
        ng++;
      end
      if (i >= 2 && gok[i-2]) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_pc !== gaddr[i-2]) begin
          n_err++;
          $display("FAIL stream_latency: got valid=%b pc=%h expected valid=1 pc=%h", o_valid, o_pc, gaddr[i-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    drain();
    n_grants = 0;
    repeat (10) cycle(1, 1, 0, 0, '0);
    n_cmp++;
    if (n_grants != DEPTH || o_req !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_grants: got grants=%0d req=%b expected grants=%0d req=0", n_grants, o_req, DEPTH);
    end
    n_pops = 0;
    repeat (8) cycle(0, 1, 1, 0, '0);
    n_cmp++;
    if (n_pops != DEPTH) begin
      n_err++;
      $display("FAIL backpressure_pops: got %0d expected %0d", n_pops, DEPTH);
    end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] first_g, first_v;
    bit          seen_g = 0, seen_v = 0;
    drain();
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    cycle(0, 0, 1, 1, 32'h0000_0103);
    n_cmp++;
    if (o_req !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_credit: got req=%b with two in flight, expected 0", o_req);
    end
    repeat (12) begin
      cycle(1, 1, 1, 0, '0);
      if (o_grant && !seen_g) begin first_g = o_addr; seen_g = 1; end
      if (o_valid && !seen_v) begin first_v = o_pc; seen_v = 1; end
    end
    n_cmp++;
    if (!seen_g || first_g !== 32'h100 || !seen_v || first_v !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_target: got grant=%b/%h valid=%b/%h expected 1/00000100 1/00000100",
               seen_g, first_g, seen_v, first_v);
    end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] tgt;
    bit          seen_g = 0;
    drain();
    cycle(1, 0, 1, 0, '0);
    tgt = $urandom & ~32'h3;
    cycle(1, 1, 1, 1, tgt | 32'(($urandom) & 3));
    n_cmp++;
    if (o_req !== 1'b1) begin
      n_err++;
      $display("FAIL collide_grant: got req=%b in redirect cycle expected 1", o_req);
    end
    repeat (12) begin
      cycle(1, 1, 1, 0, '0);
      if (o_grant && !seen_g) begin
        seen_g = 1;
        n_cmp++;
        if (o_addr !== tgt) begin
          n_err++;
          $display("FAIL collide_refetch: got %h expected %h", o_addr, tgt);
        end
      end
      if (o_valid) begin
        n_cmp++;
        if (o_pc - tgt >= 32'd48) begin
          n_err++;
          $display("FAIL collide_stale_pc: got %h expected within 48 bytes of %h", o_pc, tgt);
        end
      end
    end
  endtask

  task automatic test_hold_reset();
    logic [31:0] a0;
    drain();
    cycle(0, 1, 1, 0, '0);
    a0 = o_addr;
    repeat (5) begin
      cycle(0, 1, 1, 0, '0);
      n_cmp++;
      if (o_req !== 1'b1 || o_addr !== a0) begin
        n_err++;
        $display("FAIL hold_stable: got req=%b addr=%h expected req=1 addr=%h", o_req, o_addr, a0);
      end
    end
    repeat (4) cycle(1, 1, 1, 0, '0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    imem_gnt_i = 0; imem_rvalid_i = 0; id_ready_i = 0; redirect_i = 0;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RPC || id_valid_o !== 1'b0 ||
        id_pc_o !== 32'h0 || id_instr_o !== NOP || id_opcode_o !== 7'b0010011) begin
      n_err++;
      $display("FAIL midreset_outputs: got req=%b addr=%h valid=%b pc=%h instr=%h op=%b expected 0/%h/0/0/%h/0010011",
               imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_instr_o, id_opcode_o, RPC, NOP);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1, 1, 1, 0, '0);
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== RPC) begin
      n_err++;
      $display("FAIL refetch_after_reset: got req=%b addr=%h expected req=1 addr=%h", o_req, o_addr, RPC);
    end
    repeat (6) cycle(1, 1, 1, 0, '0);
  endtask

`ifdef RV_IFU_PERF_EN
  task automatic test_perf();
    logic [31:0] p0, p1;
    drain();
    cycle(0, 1, 1, 0, '0);
    p0 = perf_starve_o;
    repeat (6) cycle(0, 1, 1, 0, '0);
    cycle(0, 1, 0, 0, '0);
    p1 = perf_starve_o;
    n_cmp++;
    if (p1 - p0 !== 32'd7) begin
      n_err++;
      $display("FAIL perf_starve: got delta %0d expected 7", p1 - p0);
    end
  endtask
`endif

  task automatic test_random();
    n_pops = 0;
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
            ($urandom % 40) == 0, $urandom);
    end
    n_cmp++;
    if (n_pops < 100) begin
      n_err++;
      $display("FAIL random_progress: got %0d pops expected at least 100", n_pops);
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; n_pops = 0; n_grants = 0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collide();
    test_hold_reset();
`ifdef RV_IFU_PERF_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
